// File: rtl/fu_pkg.sv
// Shared definitions for the 16-bit sequential function unit: data width,
// function-select encodings, FSM state type and the add-overflow helper.
package fu_pkg;

   localparam int WIDTH = 16;

   // Function-select encodings
   localparam logic [3:0] FS_A     = 4'b0000;
   localparam logic [3:0] FS_INC   = 4'b0001;
   localparam logic [3:0] FS_ADD   = 4'b0010;
   localparam logic [3:0] FS_ADDC  = 4'b0011;
   localparam logic [3:0] FS_ADDNB = 4'b0100;
   localparam logic [3:0] FS_SUB   = 4'b0101;
   localparam logic [3:0] FS_DEC   = 4'b0110;
   localparam logic [3:0] FS_A2    = 4'b0111;
   localparam logic [3:0] FS_AND   = 4'b1000;
   localparam logic [3:0] FS_OR    = 4'b1001;
   localparam logic [3:0] FS_XOR   = 4'b1010;
   localparam logic [3:0] FS_NOTA  = 4'b1011;
   localparam logic [3:0] FS_B     = 4'b1100;
   localparam logic [3:0] FS_SHR   = 4'b1101;
   localparam logic [3:0] FS_SHL   = 4'b1110;
   localparam logic [3:0] FS_MUL   = 4'b1111;

   // Controller states, explicitly encoded so the state register is one bit
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } fu_state_e;

   // Signed overflow of x + y: operands agree in sign, result does not
   function automatic logic add_overflow(input logic x_sign,
                                         input logic y_sign,
                                         input logic r_sign);
      return (x_sign == y_sign) && (r_sign != x_sign);
   endfunction

endpackage

// File: rtl/fu_mul_seq.sv
// Unsigned 16x16 shift-add multiplier, one multiplier bit per cycle, LSB
// first. `done` is high during the cycle whose closing edge performs the
// 16th iteration, and `product` is the value after that cycle's iteration,
// so the parent can register the final result on that same edge.
module fu_mul_seq
   import fu_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 load,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [2*WIDTH-1:0] prod_next;
   logic [3:0]         count_reg;
   logic               busy_reg;

   // Partial product after the current iteration
   always_comb begin
      prod_next = prod_reg;
      if (mplier_reg[0]) begin
         prod_next = prod_reg + mcand_reg;
      end
   end

   assign busy    = busy_reg;
   assign done    = busy_reg && (count_reg == 4'd15);
   assign product = prod_next;

   // Operand latch on load, then one shift-add step per cycle while busy
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         prod_reg   <= '0;
         count_reg  <= '0;
         busy_reg   <= 1'b0;
      end else if (load) begin
         mcand_reg  <= {{WIDTH{1'b0}}, a};
         mplier_reg <= b;
         prod_reg   <= '0;
         count_reg  <= '0;
         busy_reg   <= 1'b1;
      end else if (busy_reg) begin
         prod_reg   <= prod_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         count_reg  <= count_reg + 4'd1;
         if (count_reg == 4'd15) begin
            busy_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/function_unit.sv
// Sequential function unit: single-cycle ALU/shift operations plus a
// 16-cycle shift-add multiply. F and the flags are registered and held
// until the next completed operation; DONE strobes the register-file write.
module function_unit
   import fu_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [3:0]         FS,
   input  logic               START,
   output logic [WIDTH-1:0]   F,
   output logic               V,
   output logic               C,
   output logic               N,
   output logic               Z,
   output logic               BUSY,
   output logic               DONE
);

   fu_state_e            state_reg;
   logic [WIDTH-1:0]     f_reg;
   logic                 v_reg, c_reg, n_reg, z_reg;
   logic                 done_reg;

   logic [WIDTH-1:0]     add_y;
   logic                 add_cin;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     f_next;
   logic                 v_next, c_next;

   logic                 mul_load;
   logic                 mul_busy;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;

   assign mul_load = (state_reg == IDLE) && START && (FS == FS_MUL);

   fu_mul_seq u_mul (
      .CLK     (CLK),
      .RESET   (RESET),
      .load    (mul_load),
      .a       (A),
      .b       (B),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath: one 17-bit adder shared by all arithmetic codes
   always_comb begin
      add_y   = '0;
      add_cin = 1'b0;
      case (FS)
         FS_INC:   add_cin = 1'b1;
         FS_ADD:   add_y = B;
         FS_ADDC:  begin add_y = B;  add_cin = 1'b1; end
         FS_ADDNB: add_y = ~B;
         FS_SUB:   begin add_y = ~B; add_cin = 1'b1; end
         FS_DEC:   add_y = {WIDTH{1'b1}};
         default:  ;
      endcase
      sum = {1'b0, A} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

      f_next = A;
      c_next = 1'b0;
      v_next = 1'b0;
      case (FS)
         FS_INC, FS_ADD, FS_ADDC, FS_ADDNB, FS_SUB, FS_DEC: begin
            f_next = sum[WIDTH-1:0];
            c_next = sum[WIDTH];
            v_next = add_overflow(A[WIDTH-1], add_y[WIDTH-1], sum[WIDTH-1]);
         end
         FS_AND:  f_next = A & B;
         FS_OR:   f_next = A | B;
         FS_XOR:  f_next = A ^ B;
         FS_NOTA: f_next = ~A;
         FS_B:    f_next = B;
         FS_SHR:  begin f_next = {1'b0, B[WIDTH-1:1]}; c_next = B[0]; end
         FS_SHL:  begin f_next = {B[WIDTH-2:0], 1'b0}; c_next = B[WIDTH-1]; end
         default: ;
      endcase
   end

   // Controller and output registers; DONE is a one-cycle strobe
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= IDLE;
         f_reg     <= '0;
         v_reg     <= 1'b0;
         c_reg     <= 1'b0;
         n_reg     <= 1'b0;
         z_reg     <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (START) begin
                  if (FS == FS_MUL) begin
                     state_reg <= MUL;
                  end else begin
                     f_reg    <= f_next;
                     v_reg    <= v_next;
                     c_reg    <= c_next;
                     n_reg    <= f_next[WIDTH-1];
                     z_reg    <= (f_next == '0);
                     done_reg <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (mul_done) begin
                  f_reg     <= mul_product[WIDTH-1:0];
                  v_reg     <= 1'b0;
                  c_reg     <= |mul_product[2*WIDTH-1:WIDTH];
                  n_reg     <= mul_product[WIDTH-1];
                  z_reg     <= (mul_product[WIDTH-1:0] == '0);
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign F    = f_reg;
   assign V    = v_reg;
   assign C    = c_reg;
   assign N    = n_reg;
   assign Z    = z_reg;
   assign BUSY = mul_busy;
   assign DONE = done_reg;

endmodule

// File: tb/tb_function_unit.sv
// Self-checking bench for function_unit: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_function_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] A, B;
   logic [3:0]  FS;
   logic        START;
   logic [15:0] F;
   logic        V, C, N, Z, BUSY, DONE;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] f;
      logic        v;
      logic        c;
      logic        n;
      logic        z;
   } exp_t;

   function_unit dut (
      .CLK   (CLK),
      .RESET (RESET),
      .A     (A),
      .B     (B),
      .FS    (FS),
      .START (START),
      .F     (F),
      .V     (V),
      .C     (C),
      .N     (N),
      .Z     (Z),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 CLK = ~CLK;

   // Result from the operation's meaning: true signed/unsigned values
   function automatic exp_t ref_model(input logic [3:0] fs, input logic [15:0] a,
                                      input logic [15:0] b);
      exp_t   e;
      longint ua, ub, total, true_s, sa, sb;
      logic   arith;
      e = '0; arith = 1'b0; total = 0; true_s = 0;
      ua = longint'(a); ub = longint'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      case (fs)
         4'd1:  begin arith = 1; total = ua + 1;               true_s = sa + 1;      end
         4'd2:  begin arith = 1; total = ua + ub;              true_s = sa + sb;     end
         4'd3:  begin arith = 1; total = ua + ub + 1;          true_s = sa + sb + 1; end
         4'd4:  begin arith = 1; total = ua + (65535 - ub);    true_s = sa - sb - 1; end
         4'd5:  begin arith = 1; total = ua + (65535 - ub) + 1; true_s = sa - sb;    end
         4'd6:  begin arith = 1; total = ua + 65535;           true_s = sa - 1;      end
         4'd0, 4'd7: e.f = a;
         4'd8:  e.f = a & b;
         4'd9:  e.f = a | b;
         4'd10: e.f = a ^ b;
         4'd11: e.f = ~a;
         4'd12: e.f = b;
         4'd13: begin e.f = b >> 1; e.c = b[0];  end
         4'd14: begin e.f = b << 1; e.c = b[15]; end
         default: begin
            total = ua * ub;
            e.f = total[15:0];
            e.c = (total > 65535);
         end
      endcase
      if (arith) begin
         e.f = total[15:0];
         e.c = (total > 65535);
         e.v = (true_s > 32767) || (true_s < -32768);
      end
      e.n = e.f[15];
      e.z = (e.f == 16'h0000);
      return e;
   endfunction

   // Present one request for one accepting edge; returns at edge+1
   task automatic start_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
      @(negedge CLK);
      FS = fs; A = a; B = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic run_single(input string name, input logic [3:0] fs,
                             input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e = ref_model(fs, a, b);
      start_op(fs, a, b);
      $display("op %s fs=%b a=%h b=%h -> F=%h VCNZ=%b%b%b%b DONE=%b",
               name, fs, a, b, F, V, C, N, Z, DONE);
      checks++;
      if ({F, V, C, N, Z} !== e) begin
         failures++;
         $display("FAIL %s result: got F=%h VCNZ=%b%b%b%b want F=%h VCNZ=%b%b%b%b",
                  name, F, V, C, N, Z, e.f, e.v, e.c, e.n, e.z);
      end
      checks++;
      if (DONE !== 1'b1) begin
         failures++;
         $display("FAIL %s done: got %b want 1", name, DONE);
      end
      @(posedge CLK); #1;
      checks++;
      if (DONE !== 1'b0) begin
         failures++;
         $display("FAIL %s done_pulse: got %b want 0", name, DONE);
      end
   endtask

   // Multiply with optional ignored START on cycle 5 and operand scrambling
   task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                          input bit poke_start, input bit scramble);
      exp_t e;
      int   lat;
      e = ref_model(4'b1111, a, b);
      start_op(4'b1111, a, b);
      checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
         failures++;
         $display("FAIL %s accept: got BUSY=%b DONE=%b want BUSY=1 DONE=0", name, BUSY, DONE);
      end
      lat = 0;
      while (DONE !== 1'b1 && lat < 40) begin
         @(negedge CLK);
         if (poke_start && lat == 4) begin
            FS = 4'b0001; START = 1'b1;
         end
         if (scramble) begin
            A = 16'($urandom); B = 16'($urandom);
         end
         @(posedge CLK); #1;
         START = 1'b0;
         lat++;
      end
      $display("op %s mul a=%h b=%h -> F=%h VCNZ=%b%b%b%b latency=%0d",
               name, a, b, F, V, C, N, Z, lat);
      checks++;
      if (lat != 16) begin
         failures++;
         $display("FAIL %s latency: got %0d want 16", name, lat);
      end
      checks++;
      if ({F, V, C, N, Z} !== e || BUSY !== 1'b0) begin
         failures++;
         $display("FAIL %s result: got F=%h VCNZ=%b%b%b%b BUSY=%b want F=%h VCNZ=%b%b%b%b BUSY=0",
                  name, F, V, C, N, Z, BUSY, e.f, e.v, e.c, e.n, e.z);
      end
      @(posedge CLK); #1;
      checks++;
      if (DONE !== 1'b0) begin
         failures++;
         $display("FAIL %s done_pulse: got %b want 0", name, DONE);
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RESET = 1'b1; START = 1'b0; A = '0; B = '0; FS = '0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      $display("op reset -> F=%h VCNZ=%b%b%b%b BUSY=%b DONE=%b", F, V, C, N, Z, BUSY, DONE);
      checks++;
      if ({F, V, C, N, Z, BUSY, DONE} !== 22'h0) begin
         failures++;
         $display("FAIL reset: got F=%h VCNZ=%b%b%b%b BUSY=%b DONE=%b want all 0",
                  F, V, C, N, Z, BUSY, DONE);
      end
   endtask

   task automatic test_reset_mid_mul();
      int dones;
      run_single("preload", 4'b0000, 16'h1234, 16'h0000);
      start_op(4'b1111, 16'h0003, 16'h0005);
      repeat (7) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      $display("op reset_mid_mul -> F=%h VCNZ=%b%b%b%b BUSY=%b DONE=%b",
               F, V, C, N, Z, BUSY, DONE);
      checks++;
      if ({F, V, C, N, Z, BUSY, DONE} !== 22'h0) begin
         failures++;
         $display("FAIL reset_mid_mul: got F=%h VCNZ=%b%b%b%b BUSY=%b DONE=%b want all 0",
                  F, V, C, N, Z, BUSY, DONE);
      end
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         if (DONE === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL reset_mid_mul no_done: got %0d pulses want 0", dones);
      end
      run_mul("mul_after_reset", 16'h0003, 16'h0005, 1'b0, 1'b0);
   endtask

   task automatic test_arith();
      run_single("add_carry_zero", 4'b0010, 16'hFFFF, 16'h0001);
      run_single("sub_overflow",   4'b0101, 16'h8000, 16'h0001);
      run_single("dec_zero",       4'b0110, 16'h0000, 16'h1234);
      run_single("inc_overflow",   4'b0001, 16'h7FFF, 16'h0000);
   endtask

   task automatic test_shifts();
      run_single("shl", 4'b1110, 16'h1234, 16'h8001);
      run_single("shr", 4'b1101, 16'h1234, 16'h8001);
   endtask

   task automatic test_mul_overflow();
      run_mul("mul_overflow_ignored_start", 16'h0100, 16'h0100, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops  [3] = '{4'b1000, 4'b1001, 4'b1010};
      logic [15:0] want [3] = '{16'h000F, 16'h0FFF, 16'h0FF0};
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         FS = ops[i]; A = 16'h0F0F; B = 16'h00FF; START = 1'b1;
         @(posedge CLK); #1;
         $display("op b2b fs=%b -> F=%h VCNZ=%b%b%b%b DONE=%b", ops[i], F, V, C, N, Z, DONE);
         checks++;
         if (F !== want[i] || DONE !== 1'b1 || C !== 1'b0 || V !== 1'b0) begin
            failures++;
            $display("FAIL b2b_%0d: got F=%h DONE=%b C=%b V=%b want F=%h DONE=1 C=0 V=0",
                     i, F, DONE, C, V, want[i]);
         end
      end
      START = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (DONE !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end: got DONE=%b want 0", DONE);
      end
   endtask

   task automatic test_random();
      logic [3:0]  fs;
      logic [15:0] a, b;
      for (int i = 0; i < 60; i++) begin
         fs = 4'($urandom_range(0, 15));
         a  = 16'($urandom);
         b  = 16'($urandom);
         if (i % 7 == 0) b = 16'h0000;
         if (fs == 4'b1111) run_mul("rand_mul", a, b, 1'b0, 1'b1);
         else               run_single("rand", fs, a, b);
      end
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; A = '0; B = '0; FS = '0;
      test_reset();
      test_reset_mid_mul();
      test_arith();
      test_mul_overflow();
      test_shifts();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
